// File: rtl/tile_pixel_fetch.sv
// Tile-map / texture / palette pixel pipeline for the picosoc video path.
// Four-clock fixed latency from x/y/active sample to rgb, sideband delayed to match.
module tile_pixel_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int MAP_W    = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  scroll_x,
  input  logic [9:0]  scroll_y,
  output logic [12:0] map_raddr,
  output logic        map_ren,
  input  logic [5:0]  map_rdata,
  output logic [11:0] tex_raddr,
  output logic        tex_ren,
  input  logic [2:0]  tex_rdata,
  input  logic        pal_wen,
  input  logic [2:0]  pal_waddr,
  input  logic [11:0] pal_wdata,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        de
);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } side_t;

  logic        vsync_prev_q;
  logic [9:0]  sx_l_q, sx_l_d, sy_l_q, sy_l_d;
  logic [10:0] sum_x, sum_y;
  logic [9:0]  sx, sy;
  logic [5:0]  row;
  logic [6:0]  col;
  logic [12:0] map_raddr_q, map_raddr_d;
  logic        map_ren_q;
  logic [5:0]  lo1_q, lo2_q;
  logic [11:0] tex_raddr_q, tex_raddr_d;
  logic        tex_ren_q;
  side_t       side_in;
  side_t       side_q [4];
  side_t       out_q;
  logic [11:0] pal_q [8];
  logic [11:0] rgb_q, rgb_d;
  logic        unused_sy_msb;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    sx_l_d = sx_l_q;
    sy_l_d = sy_l_q;
    // Out-of-range requests are dropped per axis; the old offset stays in force.
    if (vsync_in && !vsync_prev_q) begin
      if (scroll_x < 10'(H_ACTIVE)) sx_l_d = scroll_x;
      if (scroll_y < 10'(V_ACTIVE)) sy_l_d = scroll_y;
    end

    sum_x = {1'b0, x} + {1'b0, sx_l_q};
    sum_y = {1'b0, y} + {1'b0, sy_l_q};
    sx    = (sum_x >= 11'(H_ACTIVE)) ? 10'(sum_x - 11'(H_ACTIVE)) : sum_x[9:0];
    sy    = (sum_y >= 11'(V_ACTIVE)) ? 10'(sum_y - 11'(V_ACTIVE)) : sum_y[9:0];

    row = sy[8:3];
    col = sx[9:3];
    if (MAP_W == 80) map_raddr_d = ({7'd0, row} << 6) + ({7'd0, row} << 4) + {6'd0, col};
    else             map_raddr_d = 13'(row * MAP_W) + {6'd0, col};

    tex_raddr_d = {map_rdata, lo2_q};
    rgb_d       = side_q[3].act ? pal_q[tex_rdata] : 12'h000;
    side_in     = {active, hsync_in, vsync_in};
  end

  assign unused_sy_msb = sy[9];

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev_q <= 1'b0;
      sx_l_q       <= '0;
      sy_l_q       <= '0;
      map_raddr_q  <= '0;
      map_ren_q    <= 1'b0;
      lo1_q        <= '0;
      lo2_q        <= '0;
      tex_raddr_q  <= '0;
      tex_ren_q    <= 1'b0;
      rgb_q        <= '0;
      out_q        <= '0;
      for (int i = 0; i < 4; i++) side_q[i] <= '0;
      // NOTE: the palette is a small register array with defined power-up colours, so it is reset, unlike a RAM.
      for (int i = 0; i < 8; i++) pal_q[i] <= {3{i[2:0], 1'b0}};
    end else begin
      vsync_prev_q <= vsync_in;
      sx_l_q       <= sx_l_d;
      sy_l_q       <= sy_l_d;

      side_q[0] <= side_in;
      side_q[1] <= side_q[0];
      side_q[2] <= side_q[1];
      side_q[3] <= side_q[2];

      map_ren_q <= active;
      if (active) map_raddr_q <= map_raddr_d;
      lo1_q <= {sy[2:0], sx[2:0]};
      lo2_q <= lo1_q;

      tex_ren_q <= side_q[1].act;
      if (side_q[1].act) tex_raddr_q <= tex_raddr_d;

      rgb_q <= rgb_d;
      out_q <= side_q[3];

      // A same-edge lookup above already read the old entry.
      if (pal_wen) pal_q[pal_waddr] <= pal_wdata;
    end
  end

  assign map_raddr = map_raddr_q;
  assign map_ren   = map_ren_q;
  assign tex_raddr = tex_raddr_q;
  assign tex_ren   = tex_ren_q;
  assign rgb       = rgb_q;
  assign hsync     = out_q.hs;
  assign vsync     = out_q.vs;
  assign de        = out_q.act;

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Scoreboard bench for tile_pixel_fetch: directed scenarios then random traffic,
// with expected pixels derived from scroll/tile/texel/palette arithmetic.
module tb_tile_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y, scroll_x, scroll_y;
  logic        active, hsync_in, vsync_in;
  logic [12:0] map_raddr;
  logic        map_ren;
  logic [5:0]  map_rdata;
  logic [11:0] tex_raddr;
  logic        tex_ren;
  logic [2:0]  tex_rdata;
  logic        pal_wen;
  logic [2:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic [11:0] rgb;
  logic        hsync, vsync, de;

  tile_pixel_fetch #(.H_ACTIVE(640), .V_ACTIVE(480), .MAP_W(80)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .scroll_x(scroll_x), .scroll_y(scroll_y),
    .map_raddr(map_raddr), .map_ren(map_ren), .map_rdata(map_rdata),
    .tex_raddr(tex_raddr), .tex_ren(tex_ren), .tex_rdata(tex_rdata),
    .pal_wen(pal_wen), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de)
  );

  always #5 clk = ~clk;

  // External registered-read memories
  logic [5:0] map_mem [8192];
  logic [2:0] tex_mem [4096];
  always @(posedge clk) begin
    if (map_ren) map_rdata <= map_mem[map_raddr];
    if (tex_ren) tex_rdata <= tex_mem[tex_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int kind;   // 0 = pixel output, 1 = map port, 2 = texture port
    bit act;
    bit hs;
    bit vs;
    int addr;
    int texel;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int       sx_m, sy_m, last_map, last_tex;
  bit       vprev_m;
  logic [11:0] pal_m [8];

  function automatic void pal_defaults();
    for (int i = 0; i < 8; i++) pal_m[i] = 12'(i * 12'h222);
  endfunction

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act_v, exp_v, cyc);
    end
  endtask

  function automatic void push(input int due, input int kind, input bit a, input bit h,
                               input bit v, input int addr, input int texel);
    exp_t e;
    e.due = due; e.kind = kind; e.act = a; e.hs = h; e.vs = v; e.addr = addr; e.texel = texel;
    q.push_back(e);
  endfunction

  // Drive one pixel slot at the current negedge, record expectations, advance one cycle.
  task automatic drive(input int xv, input int yv, input bit act, input bit hs, input bit vs,
                       input bit rst, input bit pw, input int pa, input int pd);
    int sx, sy, maddr, taddr, tidx, texel;
    x = xv[9:0]; y = yv[9:0]; active = act; hsync_in = hs; vsync_in = vs;
    reset = rst; pal_wen = pw; pal_waddr = pa[2:0]; pal_wdata = pd[11:0];
    if (rst) begin
      q.delete();
      for (int d = 1; d <= 5; d++) push(cyc + d, 0, 0, 0, 0, 0, 0);
      push(cyc + 1, 1, 0, 0, 0, 0, 0);
      for (int d = 1; d <= 3; d++) push(cyc + d, 2, 0, 0, 0, 0, 0);
      sx_m = 0; sy_m = 0; vprev_m = 0; last_map = 0; last_tex = 0;
    end else begin
      sx = xv + sx_m; if (sx >= 640) sx -= 640;
      sy = yv + sy_m; if (sy >= 480) sy -= 480;
      maddr = (sy / 8) * 80 + (sx / 8);
      texel = 0;
      if (act) begin
        tidx  = int'(map_mem[maddr]);
        taddr = tidx * 64 + (sy % 8) * 8 + (sx % 8);
        texel = int'(tex_mem[taddr]);
        last_map = maddr;
        last_tex = taddr;
      end
      push(cyc + 1, 1, act, 0, 0, last_map, 0);
      push(cyc + 3, 2, act, 0, 0, last_tex, 0);
      push(cyc + 5, 0, act, hs, vs, 0, texel);
      if (vs && !vprev_m) begin
        if (scroll_x < 640) sx_m = int'(scroll_x);
        if (scroll_y < 480) sy_m = int'(scroll_y);
      end
      vprev_m = vs;
    end
    @(negedge clk);
  endtask

  // Monitor: compares whatever is due after each rising edge, then applies that edge's palette update.
  initial begin
    bit          rst_s, wen_s;
    logic [2:0]  wa_s;
    logic [11:0] wd_s;
    forever begin
      @(posedge clk);
      rst_s = reset; wen_s = pal_wen; wa_s = pal_waddr; wd_s = pal_wdata;
      #1;
      for (int i = 0; i < q.size(); ) begin
        if (q[i].due == cyc) begin
          case (q[i].kind)
            0: begin
              check("rgb", 32'(rgb), q[i].act ? 32'(pal_m[q[i].texel]) : 32'h0);
              check("de", 32'(de), 32'(q[i].act));
              check("hsync", 32'(hsync), 32'(q[i].hs));
              check("vsync", 32'(vsync), 32'(q[i].vs));
            end
            1: begin
              check("map_ren", 32'(map_ren), 32'(q[i].act));
              check("map_raddr", 32'(map_raddr), q[i].addr);
            end
            default: begin
              check("tex_ren", 32'(tex_ren), 32'(q[i].act));
              check("tex_raddr", 32'(tex_raddr), q[i].addr);
            end
          endcase
          q.delete(i);
        end else if (q[i].due < cyc) begin
          check("missed_slot", 32'(q[i].due), 32'(cyc));
          q.delete(i);
        end else begin
          i++;
        end
      end
      if (rst_s) pal_defaults();
      else if (wen_s) pal_m[wa_s] = wd_s;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit vs_r;
    int xr, yr;
    pal_defaults();
    for (int i = 0; i < 8192; i++) map_mem[i] = 6'($urandom);
    for (int i = 0; i < 4096; i++) tex_mem[i] = 3'($urandom);
    map_mem[0] = 6'd5;  tex_mem[12'h140] = 3'd3;
    map_mem[1] = 6'd7;  tex_mem[12'h1C0] = 3'd2; tex_mem[12'h1C1] = 3'd2;

    reset = 1'b1; x = '0; y = '0; active = 0; hsync_in = 0; vsync_in = 0;
    scroll_x = '0; scroll_y = '0; pal_wen = 0; pal_waddr = '0; pal_wdata = '0;
    @(negedge clk);
    repeat (3) drive(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Basic fetch: tile 5, texel 3, palette[3] = 0x0F0
    drive(0, 0, 0, 0, 0, 0, 1, 3, 12'h0F0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) drive(700, 0, 0, 0, 0, 0, 0, 0, 0);

    // Scroll latch and horizontal wrap
    scroll_x = 10'd20; scroll_y = 10'd0;
    drive(700, 500, 0, 0, 1, 0, 0, 0, 0);
    drive(700, 500, 0, 0, 0, 0, 0, 0, 0);
    drive(630, 17, 1, 0, 0, 0, 0, 0, 0);
    drive(639, 479, 1, 0, 0, 0, 0, 0, 0);
    scroll_y = 10'd33;
    drive(5, 470, 1, 0, 0, 0, 0, 0, 0);
    scroll_x = 10'd640;
    drive(700, 500, 0, 0, 1, 0, 0, 0, 0);
    drive(630, 470, 1, 0, 1, 0, 0, 0, 0);
    drive(100, 200, 1, 0, 0, 0, 0, 0, 0);

    // Blanking with an hsync pulse
    for (int i = 0; i < 3; i++) drive(650 + i, 10, 0, 1, 0, 0, 0, 0, 0);
    repeat (2) drive(660, 10, 0, 0, 0, 0, 0, 0, 0);

    // Reset with four pixels in flight
    for (int i = 0; i < 4; i++) drive(i * 8, 3, 1, i[0], 0, 0, 0, 0, 0);
    scroll_x = 10'd0; scroll_y = 10'd0;
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0);

    // Palette write racing a lookup of the same entry
    drive(8, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(9, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) drive(700, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(700, 0, 0, 0, 0, 0, 1, 2, 12'hABC);
    repeat (6) drive(700, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    vs_r = 0;
    for (int n = 0; n < 3000; n++) begin
      xr = $urandom_range(0, 799);
      yr = $urandom_range(0, 524);
      if ($urandom_range(0, 49) == 0) vs_r = ~vs_r;
      scroll_x = 10'($urandom_range(0, 700));
      scroll_y = 10'($urandom_range(0, 540));
      drive(xr, yr, (xr < 640) && (yr < 480), $urandom_range(0, 9) == 0, vs_r,
            $urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7), $urandom_range(0, 4095));
    end

    repeat (8) drive(700, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations never compared", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tile_pixel_fetch.md
# tile_pixel_fetch

Downstream consumer of the 4096×3-bit texture memory in the picosoc video path. For each pixel coordinate from the video timing generator, this block:
- looks up a 6-bit tile index in an external 80×60 tile-map RAM;
- reads the matching 3-bit texel from texture memory;
- maps the texel through an 8-entry CPU-writable palette to 12-bit RGB.

It is a fixed-latency pipeline that also forwards the delayed sync/active sideband and applies frame-synchronous hardware scroll.

## Interface
Parameters:
- H_ACTIVE, 640, visible width in pixels (multiple of 8)
- V_ACTIVE, 480, visible height in lines (multiple of 8)
- MAP_W, 80, tile-map columns (H_ACTIVE/8)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- x  in  10  pixel column from timing generator
- y  in  10  pixel line from timing generator
- active  in  1  visible-area flag
- hsync_in  in  1  horizontal sync, passed through delayed
- vsync_in  in  1  vertical sync, passed through delayed
- scroll_x  in  10  requested horizontal scroll
- scroll_y  in  10  requested vertical scroll
- map_raddr  out  13  tile-map read address
- map_ren  out  1  tile-map read enable
- map_rdata  in  6  tile index; registered, valid 1 edge after map_raddr/map_ren
- tex_raddr  out  12  texture-memory read address
- tex_ren  out  1  texture-memory read enable
- tex_rdata  in  3  texel; registered, valid 1 edge after tex_raddr/tex_ren
- pal_wen  in  1  palette write strobe
- pal_waddr  in  3  palette entry
- pal_wdata  in  12  {R[3:0],G[3:0],B[3:0]}
- rgb  out  12  pixel colour
- hsync  out  1  delayed hsync_in
- vsync  out  1  delayed vsync_in
- de  out  1  delayed active

## Operation
- Scroll latch:
  - scroll_x/scroll_y are copied to internal sx_l/sy_l only on a vsync_in rising edge (vsync_in=1 while the registered previous value is 0).
  - Each axis is latched independently.
  - A requested value ≥ H_ACTIVE (resp. ≥ V_ACTIVE) is ignored; that axis keeps its previous latched value.
- Coordinate wrap:
  - sx = x+sx_l; subtract H_ACTIVE if the result is ≥ H_ACTIVE.
  - sy = y+sy_l; subtract V_ACTIVE if the result is ≥ V_ACTIVE.
  - Both sums are 11-bit, with no truncation before the compare.
- Map address: map_raddr = sy[8:3]*MAP_W + sx[9:3], range 0..4799. Implement MAP_W=80 as (r<<6)+(r<<4)+c.
- Texture address: tex_raddr = {map_rdata[5:0], sy[2:0], sx[2:0]}. The sy/sx low bits are delayed to align with map_rdata.
- Palette:
  - 8×12-bit register array.
  - Reset value: entry i = {i,1'b0} repeated for R, G and B. Entry 0 = 0x000, entry 7 = 0xEEE.
  - A write landing on the same edge as a lookup of the same entry: the lookup returns the old value.
- Blanking:
  - map_ren and tex_ren follow the delayed active flag of their stage.
  - Addresses hold their last value while disabled.
  - rgb = 0x000 whenever the output-stage active flag is 0.
- Reset:
  - All pipeline valid/sideband registers clear; rgb, hsync, vsync, de = 0.
  - map_ren, tex_ren, map_raddr, tex_raddr = 0; sx_l, sy_l = 0; palette restored to reset values.
  - Reset mid-frame discards in-flight pixels. Outputs stay 0 until fresh inputs propagate.

## Timing
- Pipeline, with E0 the edge that samples x/y/active:
  - E0: map_raddr, map_ren registered.
  - E1: external map RAM presents map_rdata.
  - E2: tex_raddr, tex_ren registered.
  - E3: texture memory presents tex_rdata.
  - E4: rgb, hsync, vsync, de registered.
- Total latency: 4 clocks from the input sample to output, identical for every signal (sideband included). The pipeline accepts one pixel per clock with no stalls.
- Scroll takes effect on the first pixel sampled on the edge after the latching edge.
- A palette write on edge Ew affects lookups at E4 ≥ Ew+1.

## Test plan
- Scroll 0; map entry 0 = tile 5; texture[0x140] = 3; palette[3] = 0x0F0; x=0, y=0, active=1 -> 4 clocks later rgb=0x0F0, de=1; map_raddr=0, tex_raddr=0x140 seen at E0/E2.
- Scroll wrap: latch scroll_x=20 at vsync rise; x=630, y=17 -> sx=10, sy=17; map_raddr=2*80+1=161; tex_raddr low 6 bits = {3'd1,3'd2}.
- Scroll latch gating: change scroll_y mid-frame -> no effect until the next vsync_in rise; then request scroll_x=640 -> ignored, previous sx_l kept.
- Palette: pal_wen, waddr=2, wdata=0xABC on the same edge as an E4 lookup of entry 2 -> old 0x444 output; next pixel -> 0xABC.
- Blanking/sideband: active=0, hsync_in pulse -> map_ren=tex_ren=0, rgb=0x000; hsync rises exactly 4 clocks after hsync_in.
- Reset mid-stream: assert reset for 1 clock with 4 pixels in flight -> rgb/de/hsync/vsync 0 next cycle; palette back to defaults; first valid output 4 clocks after inputs resume.
